// File: rtl/arm_loader_pkg.sv
// rtl/arm_loader_pkg.sv - shared state encodings and memory-size constants for the program loader
package arm_loader_pkg;

    localparam int INS_MEM_SIZE  = 32;
    localparam int DATA_MEM_SIZE = 64;
    localparam int WORD_CNT_W    = 7;

    typedef enum logic [2:0] {
        LOAD_INS = 3'd0,
        LOAD_DAT = 3'd1,
        CHECK    = 3'd2,
        RUN      = 3'd3,
        ERROR    = 3'd4
    } loader_state_t;

    function automatic logic is_loading(input loader_state_t s);
        return (s == LOAD_INS) || (s == LOAD_DAT) || (s == CHECK);
    endfunction

endpackage

// File: rtl/arm_word_packer.sv
// rtl/arm_word_packer.sv - little-endian byte-to-word assembler with one-cycle word_valid pulse
module arm_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;

    // First three bytes shift in from the top so byte 0 ends up in [7:0]
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            shift_q  <= 24'd0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift_q  <= {byte_data, shift_q[23:8]};
        end
    end

    // Fourth byte completes the word combinationally so the top can register it on the same edge
    always_comb begin
        word_valid = byte_valid && (byte_cnt == 2'd3);
        word_data  = {byte_data, shift_q};
    end

endmodule

// File: rtl/arm_prog_loader.sv
// rtl/arm_prog_loader.sv - boot loader writing instruction/data memories and verifying a trailing checksum
module arm_prog_loader
    import arm_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        ins_we,
    output logic [31:0] ins_addr,
    output logic [31:0] ins_wdata,
    output logic        dat_we,
    output logic [31:0] dat_addr,
    output logic [31:0] dat_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    loader_state_t           state_q;
    loader_state_t           state_d;
    logic [WORD_CNT_W-1:0]   word_cnt;
    logic [31:0]             sum_q;
    logic                    xfer;
    logic                    word_valid;
    logic [31:0]             word_data;
    logic                    last_ins;
    logic                    last_dat;
    logic [31:0]             word_addr;

    assign xfer      = in_valid & in_ready;
    assign last_ins  = (word_cnt == WORD_CNT_W'(INS_MEM_SIZE - 1));
    assign last_dat  = (word_cnt == WORD_CNT_W'(DATA_MEM_SIZE - 1));
    assign word_addr = {{(30 - WORD_CNT_W){1'b0}}, word_cnt, 2'b00};

    arm_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (xfer),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_INS;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase sequencing on each completed word; RUN and ERROR hold until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_INS: if (word_valid && last_ins) state_d = LOAD_DAT;
            LOAD_DAT: if (word_valid && last_dat) state_d = CHECK;
            CHECK:    if (word_valid) state_d = (word_data == sum_q) ? RUN : ERROR;
            RUN:      state_d = RUN;
            ERROR:    state_d = ERROR;
            default:  state_d = ERROR;
        endcase
    end

    // Registered memory writes, word counter, running sum and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_we    <= 1'b0;
            ins_addr  <= 32'd0;
            ins_wdata <= 32'd0;
            dat_we    <= 1'b0;
            dat_addr  <= 32'd0;
            dat_wdata <= 32'd0;
            word_cnt  <= '0;
            sum_q     <= 32'd0;
            in_ready  <= 1'b0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ins_we   <= 1'b0;
            dat_we   <= 1'b0;
            in_ready <= is_loading(state_d);
            done     <= (state_d == RUN);
            err      <= (state_d == ERROR);
            cpu_rst  <= (state_d != RUN);
            if (word_valid && state_q == LOAD_INS) begin
                ins_we    <= 1'b1;
                ins_addr  <= word_addr;
                ins_wdata <= word_data;
                sum_q     <= sum_q + word_data;
                word_cnt  <= last_ins ? '0 : word_cnt + 1'b1;
            end else if (word_valid && state_q == LOAD_DAT) begin
                dat_we    <= 1'b1;
                dat_addr  <= word_addr;
                dat_wdata <= word_data;
                sum_q     <= sum_q + word_data;
                word_cnt  <= last_dat ? '0 : word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/arm_prog_loader.md
# arm_prog_loader

Boot-time program loader for the ARM core. It accepts a byte stream and packs it little-endian into 32-bit words. It writes the first INS_MEM_SIZE words into instruction memory and the next DATA_MEM_SIZE words into data memory, then checks a trailing 32-bit checksum. The core is held in reset until the whole image is loaded and the checksum verifies; this is the hardware writer for the memories that the simulation bench fills directly.

## Interface
- INS_MEM_SIZE, 32, instruction memory depth in words
- DATA_MEM_SIZE, 64, data memory depth in words

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte; transfer = in_valid & in_ready
- ins_we  out  1  instruction-memory write strobe, one cycle per word
- ins_addr  out  32  byte address, word aligned (word_idx*4)
- ins_wdata  out  32  instruction word
- dat_we  out  1  data-memory write strobe, one cycle per word
- dat_addr  out  32  byte address, word aligned
- dat_wdata  out  32  data word
- cpu_rst  out  1  reset to ARM core; high until load succeeds
- done  out  1  image loaded and checksum matched (sticky)
- err  out  1  checksum mismatch (sticky until rst)

## Operation
- States: LOAD_INS → LOAD_DAT → CHECK → RUN, or CHECK → ERROR.
- Byte counter (0..3) and word counter. The first byte of each word goes to bits [7:0], the fourth to [31:24].
- LOAD_INS: on the 4th byte of word k, a write of {b3,b2,b1,b0} to ins_addr=4k is issued. After word INS_MEM_SIZE-1 the state moves to LOAD_DAT and the word counter clears.
- LOAD_DAT: same packing, written to the data port at dat_addr=4k. After word DATA_MEM_SIZE-1 the state moves to CHECK.
- Running sum: 32-bit sum, modulo 2^32, of every INS and DATA word.
- CHECK: collects 4 bytes as the expected checksum word, same packing.
  - Match → RUN: done=1, cpu_rst=0.
  - Mismatch → ERROR: err=1, cpu_rst stays 1.
- RUN and ERROR are terminal. in_ready=0 in both, and extra bytes are ignored. Only rst leaves either state.
- in_ready=1 in LOAD_INS, LOAD_DAT and CHECK, so the loader never back-pressures during a load.
- ins_we and dat_we are never high in the same cycle. Both stay 0 outside their own load phase.

## Timing
- Reset values: in_ready=0, ins_we=dat_we=0, all addr and wdata=0, cpu_rst=1, done=0, err=0. State is LOAD_INS with counters and sum cleared.
- in_ready rises in the first cycle after rst deasserts.
- Write latency: the strobe, address and data are registered. They are valid for exactly one cycle, the cycle after the 4th byte's transfer edge.
- Throughput is one byte per cycle; the next word's bytes may be accepted while a write strobe is high.
- Phase boundary: the last INS write and the first DATA byte transfer may occur in the same cycle.
- Verdict: state, done/err and cpu_rst update on the edge after the 4th checksum byte is accepted. done and cpu_rst change in the same cycle.
- Reset mid-load: any partial word is discarded and no strobe is issued. cpu_rst returns to 1, and the next load restarts at address 0.
- in_valid=0 between bytes of a word is allowed; the partial word is held indefinitely.

## Structure
- Shared package/header `arm_loader_pkg` holds:
  - the state encodings (LOAD_INS, LOAD_DAT, CHECK, RUN, ERROR);
  - the default memory-size constants, shared with the core's memory modules and the bench.
- Sub-module `arm_word_packer` contains the byte counter, the 32-bit shift/assembly register and a one-cycle `word_valid` pulse.
- The top level holds the FSM, word counter, address generation, checksum sum and output registers.

## Test plan
- Nominal load: 32 INS words 0x00000001, 64 DATA words 0x00000000, checksum 0x00000020.
  - Expect 32 ins_we pulses at addr 0x00..0x7C.
  - Expect 64 dat_we pulses at 0x00..0xFC.
  - Expect done=1 and cpu_rst=0 one cycle after the last byte, err=0.
- Byte order: INS word 0 bytes 0x78,0x56,0x34,0x12 → ins_wdata=0x12345678 at ins_addr=0 one cycle after the 4th byte.
- Bad checksum: the nominal image with trailer 0x00000021 → err=1, done=0, cpu_rst stays 1, in_ready=0 afterwards.
- Gapped stream: random in_valid gaps of 0-5 cycles, including mid-word → identical memory contents and verdict to the nominal case.
- Reset mid-load: rst pulsed after 2 bytes of DATA word 10 → no dat_we for the partial word, cpu_rst=1, in_ready=0 during rst. A reload then writes from ins_addr=0.
- Post-RUN bytes: 8 extra bytes driven with in_valid=1 after done → in_ready=0, no write strobes, done, err and cpu_rst unchanged.
